vga_frame_sequencer: RTL and testbench
======================================

Name: vga_frame_sequencer

Overview:
Produces the raster side of the renderer interface: free-running `counter_H` and `counter_V`, VGA sync and display-enable. Also supplies the nine entity channels the frame-buffer renderer consumes. Game logic hands over a new entity set with a req/ack handshake. The set is copied into shadow registers only at the start of vertical blanking, so the renderer never sees a mid-frame change (no tearing).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- ENTITY_IDLE, 14'h3C00, value of an unused entity channel (ID 4'hF, orientation 0, tile 0)

Ports:
- clk  in  1  pixel clock, 25 MHz nominal
- reset  in  1  asynchronous, active-high
- entity_in_1..entity_in_7  in  14 each  staged entity from game logic ({ID[13:10], orient[9:8], tile[7:0]})
- entity_in_8_Flip, entity_in_9_Flip  in  14 each  staged flip-channel entities
- update_req  in  1  game logic has a complete entity set ready
- update_ack  out  1  one-cycle pulse: the set was latched
- entity_1..entity_7, entity_8_Flip, entity_9_Flip  out  14 each  frame-stable entities to the renderer
- counter_H  out  10  horizontal pixel count, 0..799
- counter_V  out  10  vertical line count, 0..524
- hsync  out  1  active-low
- vsync  out  1  active-low
- display_on  out  1  high inside the active area
- frame_start  out  1  one-cycle pulse at (H=0, V=0)
- vblank_start  out  1  one-cycle pulse at (H=0, V=V_ACTIVE)
- frame_count  out  8  completed-frame count, wraps

Behaviour:
- Clock and reset: one clock `clk`; `reset` is asynchronous and active-high.
- Reset values: all counters 0, hsync=1, vsync=1, display_on=0, all pulses 0, frame_count=0, every entity output = ENTITY_IDLE.
- Line and frame lengths: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- Counters:
  - counter_H increments every clk and wraps H_TOTAL-1 → 0.
  - counter_V increments only on H wrap and wraps V_TOTAL-1 → 0.
- Output registering and alignment:
  - All timing outputs are registered and aligned to the counter values visible in the same cycle, so there is zero skew between counters and syncs.
  - hsync=0 iff H_ACTIVE+H_FRONT ≤ counter_H < H_ACTIVE+H_FRONT+H_SYNC, i.e. 656..751.
  - vsync=0 iff 490 ≤ counter_V ≤ 491.
  - display_on = (counter_H < 640) && (counter_V < 480).
- Pulses:
  - frame_start=1 exactly in the cycle where the counters read (0,0).
  - frame_count increments in that same cycle and wraps 255 → 0.
  - vblank_start=1 exactly in the cycle where the counters read (0,480).
- Handshake FSM, states IDLE, PENDING:
  - IDLE → PENDING when update_req=1.
  - Latch event is the vblank_start cycle with update_req=1 (this covers PENDING, and also a request first seen in that same cycle).
  - At the latch event: all nine entity outputs ← entity_in_*, sampled in that cycle; update_ack=1 for that single cycle; FSM → IDLE.
  - New entity values are visible from the next cycle, which is within vblank.
  - If update_req drops before the latch event: return to IDLE, latch nothing, no ack.
  - update_ack never asserts outside a vblank_start cycle.
  - Game logic must drop update_req on seeing ack. If req is still high on the next vblank_start, that is a new transfer and is latched again.
- Ownership: entity_in_* may change freely while PENDING; only the values present in the latch cycle matter.
- Reset mid-frame: counters restart at (0,0), entity outputs return to ENTITY_IDLE, FSM → IDLE, any pending request is discarded.

Decomposition:
- Shared package `vga_pkg` holds:
  - the timing constants (H/V active, porches, sync, totals);
  - ENTITY_IDLE;
  - entity field slice positions (ID 13:10, orient 9:8, tile 7:0);
  - TILE_LEN_PIXEL=40, SCREENSIZE_H=16, SCREENSIZE_V=12.
- One sub-module, `vga_timing_gen`:
  - contains the counters, sync/display_on generation and both pulses;
  - the top level adds the handshake FSM and entity shadow registers.

Test Plan:
- Reset, release, run 800×525 cycles → frame_start re-pulses after exactly 420000 cycles; frame_count=1; hsync low for 96 cycles per line starting at counter_H=656.
- update_req=1 asserted at counter (100,200) with entity_in_1=14'h0512 → entity_1 stays 14'h3C00 until (0,480); update_ack pulses at (0,480); entity_1=14'h0512 the cycle after.
- update_req asserted exactly in the vblank_start cycle → latched and acked in that same cycle.
- update_req raised at (0,300), dropped at (0,400) → no ack at (0,480); entities unchanged.
- Assert reset at counter (320,240) while PENDING → counters read (0,0) immediately, entities = 14'h3C00, no ack on the following vblank_start.
- Sweep a full frame → display_on high for exactly 640×480=307200 cycles; vsync low only for counter_V 490–491 (1600 cycles).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants, entity encoding and handshake state type for the
// VGA frame sequencer and its timing generator.
package vga_pkg;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_FRONT  = 10'd16;
    localparam logic [9:0] H_SYNC   = 10'd96;
    localparam logic [9:0] H_BACK   = 10'd48;
    localparam logic [9:0] H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_FRONT  = 10'd10;
    localparam logic [9:0] V_SYNC   = 10'd2;
    localparam logic [9:0] V_BACK   = 10'd33;
    localparam logic [9:0] V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    typedef logic [13:0] entity_t;

    // Unused channel: ID 4'hF, orientation 0, tile 0.
    localparam entity_t ENTITY_IDLE = 14'h3C00;

    localparam int unsigned ENT_ID_MSB     = 32'd13;
    localparam int unsigned ENT_ID_LSB     = 32'd10;
    localparam int unsigned ENT_ORIENT_MSB = 32'd9;
    localparam int unsigned ENT_ORIENT_LSB = 32'd8;
    localparam int unsigned ENT_TILE_MSB   = 32'd7;
    localparam int unsigned ENT_TILE_LSB   = 32'd0;

    localparam int unsigned TILE_LEN_PIXEL = 32'd40;
    localparam int unsigned SCREENSIZE_H   = 32'd16;
    localparam int unsigned SCREENSIZE_V   = 32'd12;

    localparam int unsigned NUM_ENTITIES   = 32'd9;

    typedef enum logic [0:0] {
        HS_IDLE    = 1'b0,
        HS_PENDING = 1'b1
    } hs_state_t;

endpackage

// File: rtl/vga_frame_sequencer_if.sv
// Entity hand-over bundle between game logic (master) and the frame
// sequencer (slave): staged inputs, req/ack, and frame-stable outputs.
interface vga_frame_sequencer_if;
    import vga_pkg::*;

    entity_t entity_in_1;
    entity_t entity_in_2;
    entity_t entity_in_3;
    entity_t entity_in_4;
    entity_t entity_in_5;
    entity_t entity_in_6;
    entity_t entity_in_7;
    entity_t entity_in_8_Flip;
    entity_t entity_in_9_Flip;
    logic    update_req;
    logic    update_ack;
    entity_t entity_1;
    entity_t entity_2;
    entity_t entity_3;
    entity_t entity_4;
    entity_t entity_5;
    entity_t entity_6;
    entity_t entity_7;
    entity_t entity_8_Flip;
    entity_t entity_9_Flip;

    modport master (
        output entity_in_1, entity_in_2, entity_in_3, entity_in_4, entity_in_5,
               entity_in_6, entity_in_7, entity_in_8_Flip, entity_in_9_Flip,
               update_req,
        input  update_ack,
               entity_1, entity_2, entity_3, entity_4, entity_5,
               entity_6, entity_7, entity_8_Flip, entity_9_Flip
    );

    modport slave (
        input  entity_in_1, entity_in_2, entity_in_3, entity_in_4, entity_in_5,
               entity_in_6, entity_in_7, entity_in_8_Flip, entity_in_9_Flip,
               update_req,
        output update_ack,
               entity_1, entity_2, entity_3, entity_4, entity_5,
               entity_6, entity_7, entity_8_Flip, entity_9_Flip
    );

endinterface

// File: rtl/vga_timing_gen.sv
// Free-running raster counters with syncs, display enable and frame/vblank
// pulses, all registered from the next counter value so they share one edge.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter logic [9:0] H_ACT = H_ACTIVE,
    parameter logic [9:0] H_FP  = H_FRONT,
    parameter logic [9:0] H_SW  = H_SYNC,
    parameter logic [9:0] H_BP  = H_BACK,
    parameter logic [9:0] V_ACT = V_ACTIVE,
    parameter logic [9:0] V_FP  = V_FRONT,
    parameter logic [9:0] V_SW  = V_SYNC,
    parameter logic [9:0] V_BP  = V_BACK
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] counter_h,
    output logic [9:0] counter_v,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       frame_start,
    output logic       vblank_start,
    output logic [7:0] frame_count
);

    localparam logic [9:0] H_TOT    = H_ACT + H_FP + H_SW + H_BP;
    localparam logic [9:0] V_TOT    = V_ACT + V_FP + V_SW + V_BP;
    localparam logic [9:0] HS_BEGIN = H_ACT + H_FP;
    localparam logic [9:0] HS_END   = H_ACT + H_FP + H_SW;
    localparam logic [9:0] VS_BEGIN = V_ACT + V_FP;
    localparam logic [9:0] VS_END   = V_ACT + V_FP + V_SW;

    logic [9:0] h_r, v_r, h_next_s, v_next_s;
    logic       hsync_r, vsync_r, display_r, frame_start_r, vblank_r;
    logic [7:0] frame_count_r;
    logic       frame_next_s;

    // Next raster position: H wraps every line, V advances only on H wrap.
    always_comb begin
        h_next_s = h_r;
        v_next_s = v_r;
        if (h_r == H_TOT - 10'd1) begin
            h_next_s = 10'd0;
            if (v_r == V_TOT - 10'd1) begin
                v_next_s = 10'd0;
            end else begin
                v_next_s = v_r + 10'd1;
            end
        end else begin
            h_next_s = h_r + 10'd1;
        end
    end

    assign frame_next_s = (h_next_s == 10'd0) && (v_next_s == 10'd0);

    // Counters and every timing output decoded from the next position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_r           <= 10'd0;
            v_r           <= 10'd0;
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            display_r     <= 1'b0;
            frame_start_r <= 1'b0;
            vblank_r      <= 1'b0;
            frame_count_r <= 8'd0;
        end else begin
            h_r           <= h_next_s;
            v_r           <= v_next_s;
            hsync_r       <= !((h_next_s >= HS_BEGIN) && (h_next_s < HS_END));
            vsync_r       <= !((v_next_s >= VS_BEGIN) && (v_next_s < VS_END));
            display_r     <= (h_next_s < H_ACT) && (v_next_s < V_ACT);
            frame_start_r <= frame_next_s;
            vblank_r      <= (h_next_s == 10'd0) && (v_next_s == V_ACT);
            frame_count_r <= frame_count_r + {7'd0, frame_next_s};
        end
    end

    assign counter_h    = h_r;
    assign counter_v    = v_r;
    assign hsync        = hsync_r;
    assign vsync        = vsync_r;
    assign display_on   = display_r;
    assign frame_start  = frame_start_r;
    assign vblank_start = vblank_r;
    assign frame_count  = frame_count_r;

endmodule

// File: rtl/vga_frame_sequencer.sv
// Raster timing plus tear-free entity hand-over: a staged entity set is copied
// into shadow registers only in the vblank_start cycle, acknowledged there.
module vga_frame_sequencer
    import vga_pkg::*;
#(
    parameter logic [9:0] H_ACT = H_ACTIVE,
    parameter logic [9:0] H_FP  = H_FRONT,
    parameter logic [9:0] H_SW  = H_SYNC,
    parameter logic [9:0] H_BP  = H_BACK,
    parameter logic [9:0] V_ACT = V_ACTIVE,
    parameter logic [9:0] V_FP  = V_FRONT,
    parameter logic [9:0] V_SW  = V_SYNC,
    parameter logic [9:0] V_BP  = V_BACK
) (
    input  logic                  clk,
    input  logic                  reset,
    vga_frame_sequencer_if.slave  bus,
    output logic [9:0]            counter_H,
    output logic [9:0]            counter_V,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  display_on,
    output logic                  frame_start,
    output logic                  vblank_start,
    output logic [7:0]            frame_count
);

    hs_state_t state_r, state_next_s;
    entity_t   shadow_r [NUM_ENTITIES];
    entity_t   in_s     [NUM_ENTITIES];
    logic      latch_s;

    vga_timing_gen #(
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
    ) u_timing (
        .clk          (clk),
        .reset        (reset),
        .counter_h    (counter_H),
        .counter_v    (counter_V),
        .hsync        (hsync),
        .vsync        (vsync),
        .display_on   (display_on),
        .frame_start  (frame_start),
        .vblank_start (vblank_start),
        .frame_count  (frame_count)
    );

    assign in_s[0] = bus.entity_in_1;
    assign in_s[1] = bus.entity_in_2;
    assign in_s[2] = bus.entity_in_3;
    assign in_s[3] = bus.entity_in_4;
    assign in_s[4] = bus.entity_in_5;
    assign in_s[5] = bus.entity_in_6;
    assign in_s[6] = bus.entity_in_7;
    assign in_s[7] = bus.entity_in_8_Flip;
    assign in_s[8] = bus.entity_in_9_Flip;

    // A request seen in the vblank_start cycle is latched there, even if new.
    assign latch_s        = vblank_start && bus.update_req;
    assign bus.update_ack = latch_s;

    // Handshake state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= HS_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Handshake next-state: a dropped request is abandoned without latching.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            HS_IDLE: begin
                if (bus.update_req && !latch_s) begin
                    state_next_s = HS_PENDING;
                end else begin
                    state_next_s = HS_IDLE;
                end
            end
            HS_PENDING: begin
                if (!bus.update_req || latch_s) begin
                    state_next_s = HS_IDLE;
                end else begin
                    state_next_s = HS_PENDING;
                end
            end
            default: state_next_s = HS_IDLE;
        endcase
    end

    // Frame-stable shadow copy of the entity set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTITIES; i++) begin
                shadow_r[i] <= ENTITY_IDLE;
            end
        end else if (latch_s) begin
            shadow_r <= in_s;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    assign bus.entity_1      = shadow_r[0];
    assign bus.entity_2      = shadow_r[1];
    assign bus.entity_3      = shadow_r[2];
    assign bus.entity_4      = shadow_r[3];
    assign bus.entity_5      = shadow_r[4];
    assign bus.entity_6      = shadow_r[5];
    assign bus.entity_7      = shadow_r[6];
    assign bus.entity_8_Flip = shadow_r[7];
    assign bus.entity_9_Flip = shadow_r[8];

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Self-checking bench for vga_frame_sequencer on a shrunken raster so whole
// frames fit in a short run; expectations come from a position-based model.
module tb_vga_frame_sequencer;
    import vga_pkg::*;

    localparam int HA = 32'd40, HF = 32'd4, HS = 32'd8, HB = 32'd6;
    localparam int VA = 32'd30, VF = 32'd2, VS = 32'd2, VB = 32'd3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int VB_POS = VA * HT;
    localparam logic [8:0][13:0] ALL_IDLE = {9{ENTITY_IDLE}};

    logic clk = 1'b0;
    logic reset;
    logic [9:0] counter_H, counter_V;
    logic hsync, vsync, display_on, frame_start, vblank_start;
    logic [7:0] frame_count;

    int checks = 0;
    int errors = 0;
    int pos;
    int exp_fc;
    logic [8:0][13:0] exp_ent;
    logic [8:0][13:0] ins_s, outs_s;

    always #5 clk = ~clk;

    vga_frame_sequencer_if bus();

    vga_frame_sequencer #(
        .H_ACT(10'(HA)), .H_FP(10'(HF)), .H_SW(10'(HS)), .H_BP(10'(HB)),
        .V_ACT(10'(VA)), .V_FP(10'(VF)), .V_SW(10'(VS)), .V_BP(10'(VB))
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .counter_H    (counter_H),
        .counter_V    (counter_V),
        .hsync        (hsync),
        .vsync        (vsync),
        .display_on   (display_on),
        .frame_start  (frame_start),
        .vblank_start (vblank_start),
        .frame_count  (frame_count)
    );

    assign ins_s = {bus.entity_in_9_Flip, bus.entity_in_8_Flip, bus.entity_in_7,
                    bus.entity_in_6, bus.entity_in_5, bus.entity_in_4,
                    bus.entity_in_3, bus.entity_in_2, bus.entity_in_1};
    assign outs_s = {bus.entity_9_Flip, bus.entity_8_Flip, bus.entity_7,
                     bus.entity_6, bus.entity_5, bus.entity_4,
                     bus.entity_3, bus.entity_2, bus.entity_1};

    function automatic int at(int h, int v);
        return v * HT + h;
    endfunction

    function automatic logic [8:0][13:0] rand_set();
        logic [8:0][13:0] r;
        for (int i = 0; i < 9; i++) r[i] = 14'($urandom);
        return r;
    endfunction

    task automatic set_ins(input logic [8:0][13:0] v);
        bus.entity_in_1 = v[0];  bus.entity_in_2 = v[1];  bus.entity_in_3 = v[2];
        bus.entity_in_4 = v[3];  bus.entity_in_5 = v[4];  bus.entity_in_6 = v[5];
        bus.entity_in_7 = v[6];  bus.entity_in_8_Flip = v[7];  bus.entity_in_9_Flip = v[8];
    endtask

    // One clock: the model latches whatever is offered in its vblank_start cycle.
    task automatic tick();
        logic latch;
        logic [8:0][13:0] snap;
        latch = (pos == VB_POS) && (bus.update_req === 1'b1);
        snap  = ins_s;
        @(posedge clk);
        #1;
        if (latch) exp_ent = snap;
        pos = (pos + 1) % FT;
        if (pos == 0) exp_fc = (exp_fc + 1) % 256;
    endtask

    task automatic advance_to(input int target);
        for (int n = 0; n < FT && pos != target; n++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.update_req = 1'b0;
        set_ins(ALL_IDLE);
        #3;
        checks++; if (counter_H !== 10'd0 || counter_V !== 10'd0) begin errors++; $display("FAIL reset_counters: got H=%0d V=%0d, expected 0 0", counter_H, counter_V); end
        checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin errors++; $display("FAIL reset_syncs: got hs=%b vs=%b, expected 1 1", hsync, vsync); end
        checks++; if (display_on !== 1'b0) begin errors++; $display("FAIL reset_display: got %b, expected 0", display_on); end
        checks++; if (frame_start !== 1'b0 || vblank_start !== 1'b0 || bus.update_ack !== 1'b0) begin errors++; $display("FAIL reset_pulses: got fs=%b vb=%b ack=%b, expected 0 0 0", frame_start, vblank_start, bus.update_ack); end
        checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL reset_frame_count: got %0d, expected 0", frame_count); end
        checks++; if (outs_s !== ALL_IDLE) begin errors++; $display("FAIL reset_entities: got %h, expected %h", outs_s, ALL_IDLE); end
        @(posedge clk);
        #1 reset = 1'b0;
        pos = 0;
        exp_fc = 0;
        exp_ent = ALL_IDLE;
    endtask

    task automatic test_full_frame();
        int fs_at = -1, dsp = 0, vsl = 0, hsl = 0;
        int h, v;
        for (int n = 1; n <= FT; n++) begin
            tick();
            h = pos % HT;
            v = pos / HT;
            checks++; if (counter_H !== 10'(h) || counter_V !== 10'(v)) begin errors++; $display("FAIL frame_counters: got H=%0d V=%0d, expected H=%0d V=%0d", counter_H, counter_V, h, v); end
            checks++; if (hsync !== !(h >= HA + HF && h < HA + HF + HS)) begin errors++; $display("FAIL frame_hsync: got %b at H=%0d", hsync, h); end
            checks++; if (vsync !== !(v >= VA + VF && v < VA + VF + VS)) begin errors++; $display("FAIL frame_vsync: got %b at V=%0d", vsync, v); end
            checks++; if (display_on !== (h < HA && v < VA)) begin errors++; $display("FAIL frame_display: got %b at H=%0d V=%0d", display_on, h, v); end
            checks++; if (frame_start !== (pos == 0) || vblank_start !== (pos == VB_POS)) begin errors++; $display("FAIL frame_pulses: got fs=%b vb=%b at H=%0d V=%0d", frame_start, vblank_start, h, v); end
            checks++; if (bus.update_ack !== 1'b0) begin errors++; $display("FAIL frame_no_ack: got ack=%b, expected 0", bus.update_ack); end
            if (display_on === 1'b1) dsp++;
            if (vsync === 1'b0) vsl++;
            if (hsync === 1'b0) hsl++;
            if (frame_start === 1'b1 && fs_at < 0) fs_at = n;
        end
        checks++; if (fs_at !== FT) begin errors++; $display("FAIL frame_period: got %0d, expected %0d", fs_at, FT); end
        checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL frame_count_one: got %0d, expected 1", frame_count); end
        checks++; if (dsp !== HA * VA) begin errors++; $display("FAIL display_cycles: got %0d, expected %0d", dsp, HA * VA); end
        checks++; if (vsl !== VS * HT) begin errors++; $display("FAIL vsync_cycles: got %0d, expected %0d", vsl, VS * HT); end
        checks++; if (hsl !== HS * VT) begin errors++; $display("FAIL hsync_cycles: got %0d, expected %0d", hsl, HS * VT); end
    endtask

    task automatic test_latch_delayed();
        logic [8:0][13:0] v;
        logic hit = 1'b0;
        advance_to(at(10, 5));
        v = rand_set();
        v[0] = 14'h0512;
        set_ins(v);
        bus.update_req = 1'b1;
        for (int n = 0; n < FT && !hit; n++) begin
            tick();
            v = rand_set();
            v[0] = 14'h0512;
            set_ins(v);
            #1;
            if (pos == VB_POS) begin
                hit = 1'b1;
                checks++; if (bus.update_ack !== 1'b1) begin errors++; $display("FAIL delayed_ack: got %b, expected 1", bus.update_ack); end
            end else begin
                checks++; if (bus.update_ack !== 1'b0 || bus.entity_1 !== ENTITY_IDLE) begin errors++; $display("FAIL delayed_hold: got ack=%b entity_1=%h, expected 0 3c00", bus.update_ack, bus.entity_1); end
            end
        end
        checks++; if (!hit) begin errors++; $display("FAIL delayed_timeout: vblank_start cycle not reached"); end
        tick();
        bus.update_req = 1'b0;
        #1;
        checks++; if (bus.entity_1 !== 14'h0512) begin errors++; $display("FAIL delayed_entity_1: got %h, expected 0512", bus.entity_1); end
        checks++; if (outs_s !== exp_ent) begin errors++; $display("FAIL delayed_entities: got %h, expected %h", outs_s, exp_ent); end
        checks++; if (counter_H !== 10'd1 || counter_V !== 10'(VA)) begin errors++; $display("FAIL delayed_position: got H=%0d V=%0d, expected 1 %0d", counter_H, counter_V, VA); end
    endtask

    task automatic test_same_cycle();
        logic [8:0][13:0] v;
        bus.update_req = 1'b0;
        advance_to(VB_POS);
        v = rand_set();
        set_ins(v);
        bus.update_req = 1'b1;
        #1;
        checks++; if (bus.update_ack !== 1'b1) begin errors++; $display("FAIL same_cycle_ack: got %b, expected 1", bus.update_ack); end
        tick();
        bus.update_req = 1'b0;
        set_ins(rand_set());
        #1;
        checks++; if (outs_s !== v) begin errors++; $display("FAIL same_cycle_entities: got %h, expected %h", outs_s, v); end
        checks++; if (bus.update_ack !== 1'b0) begin errors++; $display("FAIL same_cycle_ack_drop: got %b, expected 0", bus.update_ack); end
    endtask

    task automatic test_drop();
        logic [8:0][13:0] saved;
        advance_to(at(0, 18));
        saved = exp_ent;
        set_ins(rand_set());
        bus.update_req = 1'b1;
        advance_to(at(0, 25));
        bus.update_req = 1'b0;
        advance_to(VB_POS);
        #1;
        checks++; if (bus.update_ack !== 1'b0) begin errors++; $display("FAIL drop_ack: got %b, expected 0", bus.update_ack); end
        tick();
        #1;
        checks++; if (outs_s !== saved) begin errors++; $display("FAIL drop_entities: got %h, expected %h", outs_s, saved); end
    endtask

    task automatic test_reset_mid();
        advance_to(at(0, VA / 2 - 2));
        set_ins(rand_set());
        bus.update_req = 1'b1;
        advance_to(at(HA / 2, VA / 2));
        reset = 1'b1;
        #1;
        checks++; if (counter_H !== 10'd0 || counter_V !== 10'd0) begin errors++; $display("FAIL midreset_counters: got H=%0d V=%0d, expected 0 0", counter_H, counter_V); end
        checks++; if (outs_s !== ALL_IDLE) begin errors++; $display("FAIL midreset_entities: got %h, expected %h", outs_s, ALL_IDLE); end
        checks++; if (frame_count !== 8'd0 || hsync !== 1'b1 || display_on !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got fc=%0d hs=%b de=%b, expected 0 1 0", frame_count, hsync, display_on); end
        bus.update_req = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        pos = 0;
        exp_fc = 0;
        exp_ent = ALL_IDLE;
        advance_to(VB_POS);
        #1;
        checks++; if (bus.update_ack !== 1'b0) begin errors++; $display("FAIL midreset_no_ack: got %b, expected 0", bus.update_ack); end
        tick();
        checks++; if (outs_s !== ALL_IDLE) begin errors++; $display("FAIL midreset_still_idle: got %h, expected %h", outs_s, ALL_IDLE); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3 * FT; n++) begin
            tick();
            set_ins(rand_set());
            if ($urandom_range(0, 63) == 0) bus.update_req = ~bus.update_req;
            #1;
            checks++; if (counter_H !== 10'(pos % HT) || counter_V !== 10'(pos / HT)) begin errors++; $display("FAIL random_counters: got H=%0d V=%0d, expected H=%0d V=%0d", counter_H, counter_V, pos % HT, pos / HT); end
            checks++; if (bus.update_ack !== ((pos == VB_POS) && bus.update_req)) begin errors++; $display("FAIL random_ack: got %b at pos %0d req %b", bus.update_ack, pos, bus.update_req); end
            checks++; if (outs_s !== exp_ent) begin errors++; $display("FAIL random_entities: got %h, expected %h", outs_s, exp_ent); end
            checks++; if (frame_count !== 8'(exp_fc)) begin errors++; $display("FAIL random_frame_count: got %0d, expected %0d", frame_count, exp_fc); end
        end
        bus.update_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_latch_delayed();
        test_same_cycle();
        test_drop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
